// File: rtl/rr_psel.sv
// rr_psel: multi-grant round-robin priority selector for the issue stage.
// Picks up to NUM_GNT ready requesters per cycle, in descending index order
// starting at the registered pointer `ptr`.
// Build option: RR_PSEL_ROTATE_EN enables the rotating pointer. Without it,
// ptr is the constant WIDTH-1 and the block is pure fixed priority.
//
// Handshake: grants are offered combinationally whenever en=1. The consumer
// asserts accept in the same cycle to take them. The pointer only moves on
// a rising edge where en && accept && gnt_valid[0]; anything else holds it.
module rr_psel #(
  parameter int WIDTH   = 16,
  parameter int NUM_GNT = 2,
  localparam int PW     = $clog2(WIDTH)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [WIDTH-1:0]                  req,
  input  logic                              en,
  input  logic                              accept,
  output logic [NUM_GNT-1:0][WIDTH-1:0]     gnt_bus,
  output logic [WIDTH-1:0]                  gnt,
  output logic [NUM_GNT-1:0]                gnt_valid,
  output logic                              req_up,
  output logic [PW-1:0]                     ptr
);

  logic [PW-1:0]                  cur_ptr;
  logic [NUM_GNT-1:0][WIDTH-1:0]  sel_bus;
  logic [PW-1:0]                  last_idx;
  logic [PW-1:0]                  idx;
  logic [2:0]                     cnt;

  // Walk indices cur_ptr, cur_ptr-1, ... (wrapping) and hand the first
  // NUM_GNT set request bits to channels 0..NUM_GNT-1 in order.
  always_comb begin
    sel_bus  = '0;
    last_idx = cur_ptr;
    cnt      = '0;
    idx      = '0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = cur_ptr - PW'(k);
      if (req[idx] && (cnt < 3'(NUM_GNT))) begin
        for (int g = 0; g < NUM_GNT; g++) begin
          if (cnt == 3'(g)) sel_bus[g][idx] = 1'b1;
        end
        last_idx = idx;
        cnt      = cnt + 3'd1;
      end
    end
  end

  // Gate the selection with en and derive the summary outputs.
  always_comb begin
    gnt_bus   = en ? sel_bus : '0;
    gnt       = '0;
    gnt_valid = '0;
    for (int g = 0; g < NUM_GNT; g++) begin
      gnt          = gnt | gnt_bus[g];
      gnt_valid[g] = |gnt_bus[g];
    end
  end

  assign req_up = |req;
  assign ptr    = cur_ptr;

`ifdef RR_PSEL_ROTATE_EN
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: one below the last granted index, so that requester
  // is the lowest priority next time; hold when nothing is taken.
  always_comb begin
    ptr_d = ptr_q;
    if (en && accept && gnt_valid[0]) ptr_d = last_idx - PW'(1);
  end

  // Pointer register; reset loads the legacy fixed-priority position.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ptr_q <= '1;
    else       ptr_q <= ptr_d;
  end

  assign cur_ptr = ptr_q;
`else
  logic unused_ok;

  assign cur_ptr   = '1;
  assign unused_ok = ^{clock, reset, accept, last_idx};
`endif

endmodule

// File: tb/tb_rr_psel.sv
// tb_rr_psel: directed checks of rr_psel with WIDTH=8, NUM_GNT=2.
// The fixed-priority table holds the pointer at 7 and so applies with or
// without RR_PSEL_ROTATE_EN; the rotation sequences follow the same macro.
module tb_rr_psel;

  localparam int W = 8;
  localparam int G = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [W-1:0]      req;
  logic              en;
  logic              accept;
  logic [G-1:0][W-1:0] gnt_bus;
  logic [W-1:0]      gnt;
  logic [G-1:0]      gnt_valid;
  logic              req_up;
  logic [2:0]        ptr;

  int n_checks = 0;
  int n_fail   = 0;

  rr_psel #(.WIDTH(W), .NUM_GNT(G)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .en        (en),
    .accept    (accept),
    .gnt_bus   (gnt_bus),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .req_up    (req_up),
    .ptr       (ptr)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] req;
    logic         en;
    logic         accept;
    logic [W-1:0] g0;
    logic [W-1:0] g1;
    logic [G-1:0] v;
    logic [W-1:0] g;
    logic         up;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic check_gnt(input string name, input logic [W-1:0] g0,
                           input logic [W-1:0] g1, input logic [G-1:0] v);
    check({name, ".g0"}, 32'(gnt_bus[0]), 32'(g0));
    check({name, ".g1"}, 32'(gnt_bus[1]), 32'(g1));
    check({name, ".valid"}, 32'(gnt_valid), 32'(v));
    check({name, ".gnt"}, 32'(gnt), 32'(g0 | g1));
  endtask

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    en     = 1'b0;
    accept = 1'b0;

    //          req    en  acc  g0     g1     v      gnt    up
    vecs[0] = '{8'hFF, 1'b1, 1'b0, 8'h80, 8'h40, 2'b11, 8'hC0, 1'b1};
    vecs[1] = '{8'h0F, 1'b1, 1'b0, 8'h08, 8'h04, 2'b11, 8'h0C, 1'b1};
    vecs[2] = '{8'h10, 1'b1, 1'b0, 8'h10, 8'h00, 2'b01, 8'h10, 1'b1};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 1'b0, 8'h80, 8'h01, 2'b11, 8'h81, 1'b1};
    vecs[6] = '{8'h01, 1'b1, 1'b0, 8'h01, 8'h00, 2'b01, 8'h01, 1'b1};
    vecs[7] = '{8'h24, 1'b1, 1'b0, 8'h20, 8'h04, 2'b11, 8'h24, 1'b1};
    vecs[8] = '{8'hFF, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00, 8'h00, 1'b1};
    vecs[9] = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h00, 2'b00, 8'h00, 1'b0};

    #3;
    check("reset.ptr", 32'(ptr), 32'd7);
    check("reset.valid", 32'(gnt_valid), 32'd0);
    check("reset.req_up", 32'(req_up), 32'd0);
    reset = 1'b0;
    tick();

    // Table: pointer stays at 7 throughout, so fixed-priority results.
    for (int i = 0; i < 10; i++) begin
      req    = vecs[i].req;
      en     = vecs[i].en;
      accept = vecs[i].accept;
      #1;
      check($sformatf("vec%0d.g0", i), 32'(gnt_bus[0]), 32'(vecs[i].g0));
      check($sformatf("vec%0d.g1", i), 32'(gnt_bus[1]), 32'(vecs[i].g1));
      check($sformatf("vec%0d.valid", i), 32'(gnt_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].g));
      check($sformatf("vec%0d.req_up", i), 32'(req_up), 32'(vecs[i].up));
      tick();
      check($sformatf("vec%0d.ptr", i), 32'(ptr), 32'd7);
    end

`ifdef RR_PSEL_ROTATE_EN
    // Rotation with all requesters ready: 7 -> 5 -> 3 -> 1 -> 7.
    do_reset();
    req = 8'hFF; en = 1'b1; accept = 1'b1;
    #1;
    check_gnt("rot0", 8'h80, 8'h40, 2'b11);
    tick();
    check("rot1.ptr", 32'(ptr), 32'd5);
    check_gnt("rot1", 8'h20, 8'h10, 2'b11);
    tick();
    check("rot2.ptr", 32'(ptr), 32'd3);
    check_gnt("rot2", 8'h08, 8'h04, 2'b11);
    tick();
    check("rot3.ptr", 32'(ptr), 32'd1);
    check_gnt("rot3", 8'h02, 8'h01, 2'b11);

    // Wrap from pointer 1 with req bits 7,1,0.
    req = 8'h83;
    #1;
    check_gnt("wrap0", 8'h02, 8'h01, 2'b11);
    tick();
    check("wrap.ptr", 32'(ptr), 32'd7);
    accept = 1'b0;
    #1;
    check_gnt("wrap1", 8'h80, 8'h02, 2'b11);
    tick();
    check("wrap.hold_ptr", 32'(ptr), 32'd7);

    // Single request from pointer 7.
    req = 8'h10; accept = 1'b1;
    #1;
    check_gnt("single", 8'h10, 8'h00, 2'b01);
    tick();
    check("single.ptr", 32'(ptr), 32'd3);

    // Hold conditions.
    do_reset();
    req = 8'h0F; en = 1'b1; accept = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("hold%0d.gnt", c), 32'(gnt), 32'h0C);
      tick();
      check($sformatf("hold%0d.ptr", c), 32'(ptr), 32'd7);
    end
    en = 1'b0; accept = 1'b1;
    #1;
    check_gnt("en_off", 8'h00, 8'h00, 2'b00);
    check("en_off.req_up", 32'(req_up), 32'd1);
    tick();
    check("en_off.ptr", 32'(ptr), 32'd7);
    en = 1'b1; req = 8'h00;
    #1;
    check("noreq.req_up", 32'(req_up), 32'd0);
    tick();
    check("noreq.ptr", 32'(ptr), 32'd7);

    // Async reset mid-operation from pointer 2.
    req = 8'h08; accept = 1'b1;
    tick();
    check("ar.ptr2", 32'(ptr), 32'd2);
    req = 8'hFF;
    #1;
    check_gnt("ar.pre", 8'h04, 8'h02, 2'b11);
    reset = 1'b1;
    #1;
    check("ar.ptr_async", 32'(ptr), 32'd7);
    check_gnt("ar.post", 8'h80, 8'h40, 2'b11);
    tick();
    check("ar.ptr_held", 32'(ptr), 32'd7);
    reset = 1'b0;
    #1;
    tick();
    check("ar.first_update", 32'(ptr), 32'd5);
`else
    // Fixed-priority build: accept never moves the pointer.
    do_reset();
    req = 8'hFF; en = 1'b1; accept = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_gnt($sformatf("fix%0d", c), 8'h80, 8'h40, 2'b11);
      tick();
      check($sformatf("fix%0d.ptr", c), 32'(ptr), 32'd7);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
